// File: rtl/fixed_point_div_scheduler.sv
// fixed_point_div_scheduler
// Request/response front end for the fixed-point signed long divider.
// Requests are queued in a small FIFO and issued one at a time to the divider.
// Each result comes back on a valid/ready stream with a status code.
// Results are saturated on divide-by-zero or overflow.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request in flight; issues the FIFO head when the slot is free
// ST_WAIT | one request in flight; waiting for the divider done pulse
module fixed_point_div_scheduler #(
    parameter int WIDTH = 8,
    parameter int FBITS = 4,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WIDTH-1:0]           i_a,
    input  logic [WIDTH-1:0]           i_b,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_div_start,
    output logic [WIDTH-1:0]           o_div_a,
    output logic [WIDTH-1:0]           o_div_b,
    input  logic                       i_div_busy,
    input  logic                       i_div_done,
    input  logic                       i_div_valid,
    input  logic                       i_div_dbz,
    input  logic                       i_div_ovf,
    input  logic [WIDTH-1:0]           i_div_val,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_q,
    output logic [1:0]                 o_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    LEVEL_FULL = LW'(DEPTH);
    localparam logic [WIDTH-1:0] Q_MAX      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [1:0]       STAT_OK    = 2'b00;
    localparam logic [1:0]       STAT_DBZ   = 2'b01;
    localparam logic [1:0]       STAT_OVF   = 2'b10;

    // FBITS only matters to the divider itself; the flags carry everything
    // this block needs, and done alone qualifies the result.
    localparam int fbits_unused = FBITS;
    logic div_valid_unused;
    assign div_valid_unused = i_div_valid;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             push;
    logic             issue;
    logic             slot_free;
    logic             sgn_diff;
    logic             a_neg;
    logic             a_zero;
    logic [WIDTH-1:0] sel_q;
    logic [1:0]       sel_status;

    assign head_a    = mem_a[rd_ptr];
    assign head_b    = mem_b[rd_ptr];
    assign o_level   = level;
    assign o_ready   = (level != LEVEL_FULL);
    assign push      = i_valid && o_ready;
    // The slot counts as free when the current result leaves this very cycle.
    assign slot_free = !o_valid || i_ready;
    assign issue     = (state == ST_IDLE) && (level != '0) && !i_div_busy && slot_free;

    // Start is combinational so an accepted request can launch the next cycle;
    // operands read as zero whenever no start is presented.
    assign o_div_start = issue;
    assign o_div_a     = issue ? head_a : '0;
    assign o_div_b     = issue ? head_b : '0;

    // FIFO storage: written on push only, no reset needed for the data.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_a[wr_ptr] <= i_a;
            mem_b[wr_ptr] <= i_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Result selection from the divider flags and the tag of the in-flight request.
    always_comb begin
        sel_q      = i_div_val;
        sel_status = STAT_OK;
        if (i_div_dbz) begin
            sel_status = STAT_DBZ;
            if (a_zero) begin
                sel_q = '0;
            end else if (a_neg) begin
                sel_q = Q_MIN;
            end else begin
                sel_q = Q_MAX;
            end
        end else if (i_div_ovf) begin
            sel_status = STAT_OVF;
            sel_q      = sgn_diff ? Q_MIN : Q_MAX;
        end
    end

    // Issue/wait sequencing, request tag and the output result register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            sgn_diff <= 1'b0;
            a_neg    <= 1'b0;
            a_zero   <= 1'b0;
            o_valid  <= 1'b0;
            o_q      <= '0;
            o_status <= STAT_OK;
        end else begin
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    // A done seen here is stale and deliberately ignored.
                    if (issue) begin
                        state    <= ST_WAIT;
                        sgn_diff <= head_a[WIDTH-1] ^ head_b[WIDTH-1];
                        a_neg    <= head_a[WIDTH-1];
                        a_zero   <= (head_a == '0);
                    end
                end
                ST_WAIT: begin
                    if (i_div_done) begin
                        state    <= ST_IDLE;
                        o_valid  <= 1'b1;
                        o_q      <= sel_q;
                        o_status <= sel_status;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_div_scheduler.sv
// Bench for fixed_point_div_scheduler: divider behavioural model plus
// in-order scoreboard of expected results.
module tb_fixed_point_div_scheduler;

    localparam int WIDTH = 8;
    localparam int FBITS = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] i_a = '0;
    logic [WIDTH-1:0] i_b = '0;
    logic [LW-1:0]    o_level;
    logic             o_div_start;
    logic [WIDTH-1:0] o_div_a;
    logic [WIDTH-1:0] o_div_b;
    logic             i_div_busy = 1'b0;
    logic             i_div_done = 1'b0;
    logic             i_div_valid = 1'b0;
    logic             i_div_dbz = 1'b0;
    logic             i_div_ovf = 1'b0;
    logic [WIDTH-1:0] i_div_val = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] o_q;
    logic [1:0]       o_status;

    fixed_point_div_scheduler #(
        .WIDTH(WIDTH),
        .FBITS(FBITS),
        .DEPTH(DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_level    (o_level),
        .o_div_start(o_div_start),
        .o_div_a    (o_div_a),
        .o_div_b    (o_div_b),
        .i_div_busy (i_div_busy),
        .i_div_done (i_div_done),
        .i_div_valid(i_div_valid),
        .i_div_dbz  (i_div_dbz),
        .i_div_ovf  (i_div_ovf),
        .i_div_val  (i_div_val),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_q        (o_q),
        .o_status   (o_status)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       dbz;
        logic       ovf;
        logic [7:0] val;
        int         lat;
    } div_rsp_t;

    typedef struct {
        logic [7:0] q;
        logic [1:0] st;
    } res_t;

    div_rsp_t dq[$];
    res_t     exp_q[$];
    int       n_vec = 0;
    int       n_bad = 0;
    int       n_valid_seen = 0;
    int       dm_cnt = 0;
    div_rsp_t dm_cur;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference fixed-point divide: (a << FBITS) / b, truncating toward zero.
    function automatic void div_ref(input logic [7:0] a, input logic [7:0] b,
                                    output logic dbz, output logic ovf, output logic [7:0] val);
        int qa, qb, q;
        qa = int'($signed(a));
        qb = int'($signed(b));
        if (qb == 0) begin
            dbz = 1'b1;
            ovf = 1'b0;
            val = 8'h5A;
        end else begin
            q   = (qa * (1 << FBITS)) / qb;
            dbz = 1'b0;
            ovf = (q > 127) || (q < -128);
            val = q[7:0];
        end
    endfunction

    // Divider model: start seen at negedge, done pulse lat cycles later.
    always @(negedge i_clk) begin
        logic       st;
        logic [7:0] sa, sb;
        st = o_div_start;
        sa = o_div_a;
        sb = o_div_b;
        i_div_done  = 1'b0;
        i_div_valid = 1'b0;
        if (dm_cnt > 0) begin
            dm_cnt--;
            if (dm_cnt == 0) begin
                i_div_done  = 1'b1;
                i_div_valid = 1'b1;
                i_div_busy  = 1'b0;
                i_div_dbz   = dm_cur.dbz;
                i_div_ovf   = dm_cur.ovf;
                i_div_val   = dm_cur.val;
            end else begin
                i_div_busy = 1'b1;
            end
        end
        if (st) begin
            if (dq.size() == 0) begin
                check_val("div_unexpected_start", 1, 0);
            end else begin
                dm_cur = dq.pop_front();
                check_val("div_a", sa, dm_cur.a);
                check_val("div_b", sb, dm_cur.b);
                dm_cnt = dm_cur.lat;
            end
        end
    end

    // Output monitor: compare each handshaken result against the scoreboard.
    always @(negedge i_clk) begin
        res_t e;
        if (i_rst_n && o_valid) begin
            n_valid_seen++;
            if (i_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("result_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("q", o_q, e.q);
                    check_val("status", o_status, e.st);
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic dbz,
                        input logic ovf, input logic [7:0] val, input int lat,
                        input logic [7:0] eq, input logic [1:0] es, output logic acc);
        div_rsp_t d;
        res_t     r;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        @(negedge i_clk);
        acc = o_ready;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        if (acc) begin
            d.a = a; d.b = b; d.dbz = dbz; d.ovf = ovf; d.val = val; d.lat = lat;
            dq.push_back(d);
            r.q = eq; r.st = es;
            exp_q.push_back(r);
        end
    endtask

    task automatic send_ref(input logic [7:0] a, input logic [7:0] b, input int lat,
                            output logic acc);
        logic       dbz, ovf;
        logic [7:0] val, eq;
        logic [1:0] es;
        div_ref(a, b, dbz, ovf, val);
        if (dbz) begin
            es = 2'b01;
            eq = (a == 8'h00) ? 8'h00 : (a[7] ? 8'h80 : 8'h7F);
        end else if (ovf) begin
            es = 2'b10;
            eq = (a[7] ^ b[7]) ? 8'h80 : 8'h7F;
        end else begin
            es = 2'b00;
            eq = val;
        end
        send(a, b, dbz, ovf, val, (dbz || ovf) ? 1 : lat, eq, es, acc);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        i_ready = 1'b1;
        while ((exp_q.size() != 0 || dq.size() != 0 || o_valid) && n < 300) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check_val(tag, (n < 300), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_valid && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check_val(tag, o_valid, 1);
    endtask

    task automatic reset_pulse(input string tag);
        i_rst_n = 1'b0;
        #1;
        check_val({tag, "_valid"}, o_valid, 0);
        check_val({tag, "_q"}, o_q, 0);
        check_val({tag, "_status"}, o_status, 0);
        check_val({tag, "_level"}, o_level, 0);
        check_val({tag, "_ready"}, o_ready, 1);
        check_val({tag, "_start"}, o_div_start, 0);
        check_val({tag, "_div_a"}, o_div_a, 0);
        check_val({tag, "_div_b"}, o_div_b, 0);
        exp_q.delete();
        dq.delete();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        int         n_acc;
        int         seen0;
        logic [7:0] ra, rb;

        repeat (2) @(posedge i_clk);
        #1;
        reset_pulse("rst0");
        i_ready = 1'b1;

        // Basic: 2.0 / 0.5 = 4.0, start the cycle after acceptance
        send(8'h20, 8'h08, 1'b0, 1'b0, 8'h40, 3, 8'h40, 2'b00, acc);
        check_val("basic_acc", acc, 1);
        check_val("start_latency", o_div_start, 1);
        check_val("start_a", o_div_a, 8'h20);
        wait_drain("drain_basic");

        // Divide-by-zero and overflow saturation
        send(8'hF0, 8'h00, 1'b1, 1'b0, 8'h33, 1, 8'h80, 2'b01, acc);
        send(8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 1, 8'h00, 2'b01, acc);
        send(8'h30, 8'h00, 1'b1, 1'b0, 8'h33, 1, 8'h7F, 2'b01, acc);
        send(8'h70, 8'h04, 1'b0, 1'b1, 8'h33, 1, 8'h7F, 2'b10, acc);
        send(8'h80, 8'h10, 1'b0, 1'b1, 8'h33, 1, 8'h80, 2'b10, acc);
        send(8'hE0, 8'h18, 1'b0, 1'b0, 8'hEB, 2, 8'hEB, 2'b00, acc);
        wait_drain("drain_sat");

        // Output stalled: six requests, DEPTH+1 accepted
        i_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            ra = 8'(8'h08 + 8'(i * 4));
            send_ref(ra, 8'h20, 3, acc);
            n_acc += int'(acc);
        end
        check_val("stall_accepted", n_acc, 5);
        wait_valid("stall_valid");
        check_val("stall_level", o_level, 4);
        check_val("stall_ready", o_ready, 0);
        wait_drain("drain_stall");

        // Simultaneous push and pop at level 2
        i_ready = 1'b0;
        send_ref(8'h10, 8'h10, 2, acc);
        send_ref(8'h18, 8'h10, 2, acc);
        send_ref(8'h28, 8'h10, 2, acc);
        wait_valid("pp_valid");
        repeat (2) @(posedge i_clk);
        #1;
        check_val("pp_level_before", o_level, 2);
        i_ready = 1'b1;
        send_ref(8'hC0, 8'h20, 2, acc);
        check_val("pp_acc", acc, 1);
        check_val("pp_level_after", o_level, 2);
        wait_drain("drain_pp");

        // Pointer wrap with random traffic and random output backpressure
        for (int i = 0; i < 20; i++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            send_ref(ra, rb, int'($urandom_range(1, 4)), acc);
        end
        wait_drain("drain_wrap");

        // Reset with a result held in the output register and a queued request
        i_ready = 1'b0;
        send_ref(8'h20, 8'h10, 2, acc);
        send_ref(8'h40, 8'h10, 2, acc);
        wait_valid("rstv_valid");
        reset_pulse("rst_valid");
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;

        // Reset while waiting on the divider; its late done must be ignored
        send(8'h30, 8'h10, 1'b0, 1'b0, 8'h30, 6, 8'h30, 2'b00, acc);
        repeat (2) @(posedge i_clk);
        #1;
        reset_pulse("rst_wait");
        seen0 = n_valid_seen;
        repeat (10) @(posedge i_clk);
        #1;
        check_val("stale_done_valid", n_valid_seen - seen0, 0);
        check_val("stale_done_level", o_level, 0);

        // Normal operation resumes after reset
        send_ref(8'h20, 8'h08, 3, acc);
        wait_drain("drain_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
